audio_fx_core: RTL and testbench

//  Parametrised multi-mode stereo effect engine between in_i2s and out_i2s, on system clk.

---
 rtl/audio_fx_pkg.sv | 34 +++
 rtl/audio_delay_ram.sv | 33 +++
 rtl/audio_fx_core.sv | 185 ++++++++++++++++++
 tb/tb_audio_fx_core.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_fx_pkg.sv
// Shared types and helpers for the stereo effect engine.
package audio_fx_pkg;

   typedef enum logic [1:0] {
      FX_BYPASS    = 2'b00,
      FX_ECHO      = 2'b01,
      FX_TREMOLO   = 2'b10,
      FX_OVERDRIVE = 2'b11
   } fx_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_MIX   = 2'd2,
      ST_WRITE = 2'd3
   } fx_state_e;

   // Clamp a wide signed value into the signed range of 'width' bits.
   function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                   input int unsigned       width);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (width - 32'd1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (value > hi) begin
         saturate = hi;
      end else if (value < lo) begin
         saturate = lo;
      end else begin
         saturate = value;
      end
   endfunction

endpackage

// File: rtl/audio_delay_ram.sv
// Stereo delay line storage: one write port, one registered read port.
module audio_delay_ram
   import audio_fx_pkg::*;
#(
   parameter int WIDTH      = 48,
   parameter int DEPTH      = 4096,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [WIDTH-1:0]      rd_data
);
   logic [WIDTH-1:0] mem [DEPTH];

   // Write port.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read port, one cycle of latency.
   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/audio_fx_core.sv
// Runtime-selectable stereo effect engine (bypass, regenerative echo, tremolo,
// overdrive) built around a shared delay line; one sample pair per four-cycle pass.
module audio_fx_core
   import audio_fx_pkg::*;
#(
   parameter int DATA_WIDTH  = 24,
   parameter int DELAY_DEPTH = 4096,
   parameter int ADDR_WIDTH  = $clog2(DELAY_DEPTH),
   parameter int GAIN_WIDTH  = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   input  logic signed [DATA_WIDTH-1:0] in_left,
   input  logic signed [DATA_WIDTH-1:0] in_right,
   input  logic [1:0]                   mode,
   input  logic [ADDR_WIDTH-1:0]        delay_len,
   input  logic [GAIN_WIDTH-1:0]        feedback,
   input  logic [DATA_WIDTH-2:0]        clip_level,
   output logic                         out_valid,
   output logic signed [DATA_WIDTH-1:0] out_left,
   output logic signed [DATA_WIDTH-1:0] out_right,
   output logic                         busy,
   output logic                         sample_drop
);
   localparam int PROD_WIDTH = DATA_WIDTH + GAIN_WIDTH + 1;
   localparam logic [ADDR_WIDTH:0] FILL_MAX = (ADDR_WIDTH + 1)'(DELAY_DEPTH);

   fx_state_e                    state;
   fx_mode_e                     cur_mode;
   logic signed [DATA_WIDTH-1:0] x_left, x_right, d_left, d_right, y_left, y_right;
   logic [ADDR_WIDTH-1:0]        eff_delay, wr_ptr, rd_addr;
   logic [ADDR_WIDTH:0]          fill_count;
   logic [GAIN_WIDTH-1:0]        gain, lfo;
   logic                         lfo_down, delay_ok;
   logic [DATA_WIDTH-2:0]        clip;
   logic [2*DATA_WIDTH-1:0]      wr_data, rd_data;

   function automatic logic signed [DATA_WIDTH-1:0] fx_channel(
      input fx_mode_e                     m,
      input logic signed [DATA_WIDTH-1:0] x,
      input logic signed [DATA_WIDTH-1:0] d,
      input logic [GAIN_WIDTH-1:0]        fb,
      input logic [GAIN_WIDTH-1:0]        lv,
      input logic [DATA_WIDTH-2:0]        lim
   );
      logic signed [PROD_WIDTH-1:0] prod;
      logic signed [DATA_WIDTH-1:0] lim_s;
      logic signed [63:0]           wide;
      prod  = {PROD_WIDTH{1'b0}};
      lim_s = $signed({1'b0, lim});
      case (m)
         FX_ECHO: begin
            prod = PROD_WIDTH'(d) * PROD_WIDTH'($signed({1'b0, fb}));
            wide = 64'(x) + 64'(prod >>> GAIN_WIDTH);
         end
         FX_TREMOLO: begin
            prod = PROD_WIDTH'(x) * PROD_WIDTH'($signed({1'b0, lv}));
            wide = 64'(prod >>> GAIN_WIDTH);
         end
         FX_OVERDRIVE: begin
            if (x > lim_s) begin
               wide = 64'(lim_s);
            end else if (x < -lim_s) begin
               wide = 64'(-lim_s);
            end else begin
               wide = 64'(x);
            end
         end
         default: wide = 64'(x);
      endcase
      wide = saturate(wide, DATA_WIDTH);
      return wide[DATA_WIDTH-1:0];
   endfunction

   assign rd_addr = wr_ptr - eff_delay;

   // Delayed samples count as silence until that much history has been written.
   always_comb begin
      if (delay_ok) begin
         d_left  = $signed(rd_data[2*DATA_WIDTH-1:DATA_WIDTH]);
         d_right = $signed(rd_data[DATA_WIDTH-1:0]);
      end else begin
         d_left  = {DATA_WIDTH{1'b0}};
         d_right = {DATA_WIDTH{1'b0}};
      end
      y_left  = fx_channel(cur_mode, x_left,  d_left,  gain, lfo, clip);
      y_right = fx_channel(cur_mode, x_right, d_right, gain, lfo, clip);
   end

   audio_delay_ram #(
      .WIDTH      (2 * DATA_WIDTH),
      .DEPTH      (DELAY_DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk     (clk),
      .wr_en   (state == ST_WRITE),
      .wr_addr (wr_ptr),
      .wr_data (wr_data),
      .rd_en   (state == ST_READ),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // Sample sequencer, output registers, pointer/fill bookkeeping and LFO.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         cur_mode    <= FX_BYPASS;
         x_left      <= {DATA_WIDTH{1'b0}};
         x_right     <= {DATA_WIDTH{1'b0}};
         eff_delay   <= {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
         gain        <= {GAIN_WIDTH{1'b0}};
         clip        <= {(DATA_WIDTH-1){1'b0}};
         wr_ptr      <= {ADDR_WIDTH{1'b0}};
         fill_count  <= {(ADDR_WIDTH+1){1'b0}};
         lfo         <= {GAIN_WIDTH{1'b0}};
         lfo_down    <= 1'b0;
         delay_ok    <= 1'b0;
         wr_data     <= {(2*DATA_WIDTH){1'b0}};
         out_valid   <= 1'b0;
         out_left    <= {DATA_WIDTH{1'b0}};
         out_right   <= {DATA_WIDTH{1'b0}};
         busy        <= 1'b0;
         sample_drop <= 1'b0;
      end else begin
         out_valid   <= 1'b0;
         sample_drop <= in_valid && (state != ST_IDLE);
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  x_left    <= in_left;
                  x_right   <= in_right;
                  cur_mode  <= fx_mode_e'(mode);
                  eff_delay <= (delay_len == {ADDR_WIDTH{1'b0}}) ?
                               {{(ADDR_WIDTH-1){1'b0}}, 1'b1} : delay_len;
                  gain      <= feedback;
                  clip      <= clip_level;
                  busy      <= 1'b1;
                  state     <= ST_READ;
               end
            end
            ST_READ: begin
               delay_ok <= fill_count >= {1'b0, eff_delay};
               state    <= ST_MIX;
            end
            ST_MIX: begin
               out_left  <= y_left;
               out_right <= y_right;
               out_valid <= 1'b1;
               // Echo regenerates its own output; every other mode keeps dry history.
               if (cur_mode == FX_ECHO) begin
                  wr_data <= {y_left, y_right};
               end else begin
                  wr_data <= {x_left, x_right};
               end
               state <= ST_WRITE;
            end
            ST_WRITE: begin
               wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
               if (fill_count != FILL_MAX) begin
                  fill_count <= fill_count + (ADDR_WIDTH + 1)'(1);
               end
               if (!lfo_down) begin
                  if (lfo == {GAIN_WIDTH{1'b1}}) begin
                     lfo      <= lfo - GAIN_WIDTH'(1);
                     lfo_down <= 1'b1;
                  end else begin
                     lfo <= lfo + GAIN_WIDTH'(1);
                  end
               end else if (lfo == {GAIN_WIDTH{1'b0}}) begin
                  lfo      <= lfo + GAIN_WIDTH'(1);
                  lfo_down <= 1'b0;
               end else begin
                  lfo <= lfo - GAIN_WIDTH'(1);
               end
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_audio_fx_core.sv
// Self-checking bench: directed and random stereo samples into a 4096-deep and a
// 16-deep engine, compared against an arithmetic reference model of each.
module tb_audio_fx_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               reset, in_valid;
   logic signed [23:0] in_left, in_right;
   logic [1:0]         mode;
   logic [11:0]        dl_big;
   logic [3:0]         dl_small;
   logic [7:0]         feedback;
   logic [22:0]        clip_level;
   logic               ov_b, busy_b, drop_b, ov_s, busy_s, drop_s;
   logic signed [23:0] ol_b, or_b, ol_s, or_s;

   int     errors = 0;
   int     checks = 0;
   longint hist [4][$];
   int     n_proc;
   longint exp_l [2];
   longint exp_r [2];
   logic signed [23:0] last_l, last_r;

   audio_fx_core dut_big (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_left(in_left), .in_right(in_right),
      .mode(mode), .delay_len(dl_big), .feedback(feedback), .clip_level(clip_level),
      .out_valid(ov_b), .out_left(ol_b), .out_right(or_b), .busy(busy_b), .sample_drop(drop_b)
   );

   audio_fx_core #(.DELAY_DEPTH(16)) dut_small (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_left(in_left), .in_right(in_right),
      .mode(mode), .delay_len(dl_small), .feedback(feedback), .clip_level(clip_level),
      .out_valid(ov_s), .out_left(ol_s), .out_right(or_s), .busy(busy_s), .sample_drop(drop_s)
   );

   task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
      end
   endtask

   function automatic longint sat24(input longint v);
      if (v > 64'sd8388607) return 64'sd8388607;
      if (v < -64'sd8388608) return -64'sd8388608;
      return v;
   endfunction

   // Triangle wave: position within a 510-sample period since reset.
   function automatic longint lfo_at(input int n);
      int p;
      p = n % 510;
      return (p <= 255) ? longint'(p) : longint'(510 - p);
   endfunction

   task automatic model_sample(input longint xl, input longint xr);
      longint x, d, y, fbv, clv, lv;
      int eff, n, q;
      fbv = feedback;
      clv = clip_level;
      lv  = lfo_at(n_proc);
      for (int k = 0; k < 2; k++) begin
         eff = (k == 0) ? int'(dl_big) : int'(dl_small);
         if (eff == 0) eff = 1;
         for (int c = 0; c < 2; c++) begin
            x = (c == 0) ? xl : xr;
            q = 2 * k + c;
            n = hist[q].size();
            d = (n >= eff) ? hist[q][n - eff] : 64'sd0;
            case (mode)
               2'b00:   y = x;
               2'b01:   y = sat24(x + ((d * fbv) >>> 8));
               2'b10:   y = sat24((x * lv) >>> 8);
               default: y = (x > clv) ? clv : ((x < -clv) ? -clv : x);
            endcase
            if (c == 0) exp_l[k] = y; else exp_r[k] = y;
            hist[q].push_back((mode == 2'b01) ? y : x);
         end
      end
      n_proc++;
   endtask

   task automatic clear_model();
      for (int q = 0; q < 4; q++) hist[q].delete();
      n_proc = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      clear_model();
   endtask

   // One sample through both engines; optionally a second strobe in MIX or WRITE.
   task automatic run_sample(input logic signed [23:0] l, input logic signed [23:0] r,
                             input bit drop_mid, input bit drop_wr, input string tag);
      model_sample(longint'(l), longint'(r));
      @(negedge clk);
      in_valid = 1'b1; in_left = l; in_right = r;
      @(negedge clk);
      in_valid = 1'b0;
      check({tag, "_busy_read"}, busy_b, 1'b1);
      check({tag, "_ov_read"}, ov_b, 1'b0);
      @(negedge clk);
      check({tag, "_busy_mix"}, busy_b, 1'b1);
      check({tag, "_ov_mix"}, ov_s, 1'b0);
      if (drop_mid) begin
         in_valid = 1'b1; in_left = ~l; in_right = ~r;
      end
      @(negedge clk);
      in_valid = drop_wr;
      if (drop_wr) begin
         in_left = 24'sd99; in_right = -24'sd99;
      end
      last_l = ol_b;
      last_r = or_b;
      check({tag, "_ov_big"}, ov_b, 1'b1);
      check({tag, "_ov_small"}, ov_s, 1'b1);
      check({tag, "_big_l"}, ol_b, exp_l[0]);
      check({tag, "_big_r"}, or_b, exp_r[0]);
      check({tag, "_small_l"}, ol_s, exp_l[1]);
      check({tag, "_small_r"}, or_s, exp_r[1]);
      check({tag, "_drop_mix"}, drop_b, drop_mid);
      check({tag, "_busy_wr"}, busy_s, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      check({tag, "_ov_idle"}, ov_b, 1'b0);
      check({tag, "_busy_idle"}, busy_b, 1'b0);
      check({tag, "_drop_wr"}, drop_s, drop_wr);
   endtask

   initial begin
      logic signed [23:0] xl, xr;
      reset = 1'b1; in_valid = 1'b0; in_left = 24'sd0; in_right = 24'sd0;
      mode = 2'b00; dl_big = 12'd4; dl_small = 4'd4; feedback = 8'd128; clip_level = 23'd1000;
      clear_model();
      repeat (3) @(negedge clk);
      check("rst_ov", ov_b, 1'b0);
      check("rst_l", ol_b, 24'sd0);
      check("rst_r", or_s, 24'sd0);
      check("rst_busy", busy_b, 1'b0);
      check("rst_drop", drop_b, 1'b0);
      reset = 1'b0;

      // Bypass
      run_sample(24'sh123456, -24'sd5, 1'b0, 1'b0, "bypass");
      check("bypass_l_const", last_l, 24'sh123456);
      check("bypass_r_const", last_r, -24'sd5);

      // Echo impulse, delay 4, gain 0.5
      do_reset();
      mode = 2'b01; dl_big = 12'd4; dl_small = 4'd4; feedback = 8'd128;
      run_sample(24'sd8388607, 24'sd0, 1'b0, 1'b0, "echo_imp");
      for (int i = 1; i <= 8; i++) begin
         run_sample(24'sd0, 24'sd0, 1'b0, 1'b0, "echo_tail");
         if (i < 4) check("echo_silent", last_l, 24'sd0);
         if (i == 4) check("echo_s4", last_l, 24'sd4194303);
         if (i == 8) check("echo_s8", last_l, 24'sd2097151);
      end

      // Echo cold start with a long delay
      do_reset();
      dl_big = 12'd100; dl_small = 4'd15; feedback = 8'($urandom_range(1, 255));
      for (int i = 0; i < 104; i++) begin
         xl = 24'($urandom); xr = 24'($urandom);
         run_sample(xl, xr, 1'b0, 1'b0, "cold");
         if (i < 100) check("cold_dry", last_l, xl);
      end

      // Echo across pointer wrap of the 16-deep line
      do_reset();
      dl_big = 12'd15; dl_small = 4'd15; feedback = 8'd128;
      for (int i = 0; i < 40; i++) begin
         xl = 24'(i * 100000); xr = 24'(-i * 1000);
         run_sample(xl, xr, 1'b0, 1'b0, "wrap");
      end

      // Tremolo on a constant, through the triangle peak
      do_reset();
      mode = 2'b10;
      for (int i = 0; i < 300; i++) run_sample(24'sd1000, -24'sd1000, 1'b0, 1'b0, "trem");

      // Overdrive
      mode = 2'b11; clip_level = 23'd1000;
      run_sample(24'sd5000, 24'sd12, 1'b0, 1'b0, "od_pos");
      check("od_pos_const", last_l, 24'sd1000);
      run_sample(-24'sd5000, -24'sd12, 1'b0, 1'b0, "od_neg");
      check("od_neg_const", last_l, -24'sd1000);
      run_sample(-24'sd8388608, 24'sd8388607, 1'b0, 1'b0, "od_min");
      check("od_min_const", last_l, -24'sd1000);

      // Strobes while busy
      mode = 2'b00;
      run_sample(24'sd111, 24'sd222, 1'b1, 1'b0, "drop_mix");
      check("drop_mix_keep", last_l, 24'sd111);
      run_sample(24'sd333, 24'sd444, 1'b0, 1'b1, "drop_wr");
      run_sample(24'sd555, 24'sd666, 1'b0, 1'b0, "after_drop");

      // Echo saturation
      do_reset();
      mode = 2'b01; dl_big = 12'd1; dl_small = 4'd1; feedback = 8'd255;
      run_sample(24'sd8388607, 24'sd0, 1'b0, 1'b0, "sat_seed");
      run_sample(24'sd8000000, 24'sd0, 1'b0, 1'b0, "sat");
      check("sat_const", last_l, 24'sd8388607);

      // Reset while in MIX
      mode = 2'b00;
      run_sample(24'sd1234, 24'sd4321, 1'b0, 1'b0, "pre_rst");
      @(negedge clk);
      in_valid = 1'b1; in_left = 24'sd42; in_right = 24'sd43;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("mixrst_l", ol_b, 24'sd0);
      check("mixrst_busy", busy_b, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      clear_model();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("mixrst_no_ov", ov_b, 1'b0);
      end
      run_sample(24'sd777, -24'sd777, 1'b0, 1'b0, "post_rst");
      check("post_rst_const", last_l, 24'sd777);

      // Random mix of modes, controls and stray strobes
      for (int i = 0; i < 200; i++) begin
         mode = 2'($urandom_range(0, 3));
         dl_big = 12'($urandom_range(0, 40));
         dl_small = 4'($urandom_range(0, 15));
         feedback = 8'($urandom);
         clip_level = 23'($urandom);
         xl = 24'($urandom); xr = 24'($urandom);
         if ($urandom_range(0, 7) == 0) xl = 24'sh7FFFFF;
         if ($urandom_range(0, 7) == 0) xr = 24'sh800000;
         run_sample(xl, xr, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
